// File: rtl/intcode_mem_pkg.sv
// Shared types and default sizing for the intcode word memory.
package intcode_mem_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_WORD_W = 64;
  localparam int DEF_NUM_RD = 3;

  // CLEAR zeroes the array one word per cycle after reset; RUN serves requests.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/mem_rd_port.sv
// One synchronous read port with write-first bypass against the winning write.
module mem_rd_port
  import intcode_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,        // already qualified with RUN by the top
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] arr_data,  // current array contents at addr
  input  logic              wr_en,     // winning write this cycle
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid
);

  logic hit;

  assign hit = wr_en && (wr_addr == addr);

  // Register the read one cycle after the request; data holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= en;
      if (en) begin
        rd_data <= hit ? wr_data : arr_data;
      end
    end
  end

endmodule

// File: rtl/intcode_mem_mp.sv
// Multi-read-port word memory: hardware clear after reset, one write port,
// streaming program loader, and a registered copy of word 0.
//
// Handshake: rd_en, wr_en and load_valid are single-cycle qualifiers with no
// ready. In RUN every request is taken on the clock edge it is presented; in
// CLEAR (busy=1) every request is dropped. rd_valid is a one-cycle strobe that
// the consumer must take when it is high; there is no backpressure.
module intcode_mem_mp
  import intcode_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WORD_W = DEF_WORD_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           busy,
  input  logic                           load_start,
  input  logic                           load_valid,
  input  logic [WORD_W-1:0]              load_data,
  output logic                           load_ovf,
  input  logic [NUM_RD-1:0]              rd_en,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD-1:0][WORD_W-1:0]  rd_data,
  output logic [NUM_RD-1:0]              rd_valid,
  input  logic                           wr_en,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [WORD_W-1:0]              wr_data,
  output logic [WORD_W-1:0]              word0,
  output state_e                         state_dbg
);

  localparam int DEPTH = 1 << ADDR_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr;
  logic [ADDR_W:0]     load_ptr;    // extra bit: value DEPTH means full
  logic                load_full;
  logic                req_ok;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [WORD_W-1:0]   mem_wd;
  logic [WORD_W-1:0]   mem [DEPTH];

  assign load_full = load_ptr[ADDR_W];
  assign state_dbg = state_q;

  // State register; reset from any state restarts the clear sweep.
  always_ff @(posedge clk) begin
    if (rst) state_q <= CLEAR;
    else     state_q <= state_d;
  end

  // Next state: leave CLEAR once the last address has been zeroed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (clr_ptr == '1) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  // Outputs: busy flag and the single winning array write (clear > load > write).
  always_comb begin
    busy   = (state_q == CLEAR);
    req_ok = (state_q == RUN) && !rst;
    mem_we = 1'b0;
    mem_wa = clr_ptr;
    mem_wd = '0;
    if (state_q == CLEAR) begin
      mem_we = 1'b1;
    end else if (req_ok) begin
      if (load_valid) begin
        // A load owns the cycle even when it overflows; the core write is lost.
        if (load_start || !load_full) begin
          mem_we = 1'b1;
          mem_wa = load_start ? '0 : load_ptr[ADDR_W-1:0];
          mem_wd = load_data;
        end
      end else if (wr_en) begin
        mem_we = 1'b1;
        mem_wa = wr_addr;
        mem_wd = wr_data;
      end
    end
  end

  // Clear sweep pointer; wraps to 0 naturally after the last address.
  always_ff @(posedge clk) begin
    if (rst)                    clr_ptr <= '0;
    else if (state_q == CLEAR)  clr_ptr <= clr_ptr + ADDR_W'(1);
  end

  // Loader pointer and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_ptr <= '0;
      load_ovf <= 1'b0;
    end else if (state_q == RUN) begin
      if (load_start) begin
        load_ptr <= load_valid ? (ADDR_W+1)'(1) : '0;
        load_ovf <= 1'b0;
      end else if (load_valid) begin
        if (load_full) load_ovf <= 1'b1;
        else           load_ptr <= load_ptr + (ADDR_W+1)'(1);
      end
    end
  end

  // Storage array; no reset, contents are zeroed by the clear sweep.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Shadow of address 0, updated on the same edge as the array.
  always_ff @(posedge clk) begin
    if (rst)                          word0 <= '0;
    else if (mem_we && mem_wa == '0)  word0 <= mem_wd;
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [WORD_W-1:0] arr_word;
    assign arr_word = mem[rd_addr[g]];

    mem_rd_port #(
      .ADDR_W (ADDR_W),
      .WORD_W (WORD_W)
    ) u_port (
      .clk      (clk),
      .rst      (rst),
      .en       (rd_en[g] && req_ok),
      .addr     (rd_addr[g]),
      .arr_data (arr_word),
      .wr_en    (mem_we),
      .wr_addr  (mem_wa),
      .wr_data  (mem_wd),
      .rd_data  (rd_data[g]),
      .rd_valid (rd_valid[g])
    );
  end

endmodule
